// File: rtl/lsu_pkg.sv
// Shared opcodes, FSM state type and opcode predicates for the load/store unit.
package lsu_pkg;

  localparam int LSU_ARGS_WIDTH = 8;

  localparam logic [LSU_ARGS_WIDTH-1:0] LSU_NONE = 8'd0;
  localparam logic [LSU_ARGS_WIDTH-1:0] LSU_LB   = 8'd1;
  localparam logic [LSU_ARGS_WIDTH-1:0] LSU_LH   = 8'd2;
  localparam logic [LSU_ARGS_WIDTH-1:0] LSU_LW   = 8'd3;
  localparam logic [LSU_ARGS_WIDTH-1:0] LSU_LBU  = 8'd4;
  localparam logic [LSU_ARGS_WIDTH-1:0] LSU_LHU  = 8'd5;
  localparam logic [LSU_ARGS_WIDTH-1:0] LSU_SB   = 8'd6;
  localparam logic [LSU_ARGS_WIDTH-1:0] LSU_SH   = 8'd7;
  localparam logic [LSU_ARGS_WIDTH-1:0] LSU_SW   = 8'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  function automatic logic is_load(input logic [LSU_ARGS_WIDTH-1:0] t);
    return (t == LSU_LB) || (t == LSU_LH) || (t == LSU_LW) ||
           (t == LSU_LBU) || (t == LSU_LHU);
  endfunction

  function automatic logic is_store(input logic [LSU_ARGS_WIDTH-1:0] t);
    return (t == LSU_SB) || (t == LSU_SH) || (t == LSU_SW);
  endfunction

endpackage

// File: rtl/lsu_fmt.sv
// Combinational data formatting: store lanes/strobes, load extract/extend and the alignment check.
module lsu_fmt
  import lsu_pkg::*;
(
  input  logic [LSU_ARGS_WIDTH-1:0] chk_type,
  input  logic [1:0]                chk_addr,
  output logic                      misaligned,
  input  logic [LSU_ARGS_WIDTH-1:0] lsu_type,
  input  logic [1:0]                addr_lo,
  input  logic [31:0]               rs2,
  input  logic [31:0]               rdata,
  output logic                      we,
  output logic [31:0]               wdata,
  output logic [3:0]                wstrb,
  output logic [31:0]               load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfwords need an even address, words need a 4-byte aligned address; the check uses the incoming op.
  always_comb begin
    misaligned = 1'b0;
    if ((chk_type == LSU_LH) || (chk_type == LSU_LHU) || (chk_type == LSU_SH))
      misaligned = chk_addr[0];
    else if ((chk_type == LSU_LW) || (chk_type == LSU_SW))
      misaligned = (chk_addr != 2'b00);
  end

  // Replicate store data into every lane and pick the strobes for the addressed bytes.
  always_comb begin
    we    = is_store(lsu_type);
    wdata = 32'h0;
    wstrb = 4'b0000;
    if (lsu_type == LSU_SB) begin
      wdata = {4{rs2[7:0]}};
      wstrb = 4'b0001 << addr_lo;
    end else if (lsu_type == LSU_SH) begin
      wdata = {2{rs2[15:0]}};
      wstrb = 4'b0011 << addr_lo;
    end else if (lsu_type == LSU_SW) begin
      wdata = rs2;
      wstrb = 4'b1111;
    end
  end

  // Pull the addressed byte/half out of the read word and extend it to 32 bits.
  always_comb begin
    byte_sel  = rdata[{addr_lo, 3'b000} +: 8];
    half_sel  = rdata[{addr_lo[1], 4'b0000} +: 16];
    load_data = 32'h0;
    case (lsu_type)
      LSU_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
      LSU_LBU: load_data = {24'h0, byte_sel};
      LSU_LH:  load_data = {{16{half_sel[15]}}, half_sel};
      LSU_LHU: load_data = {16'h0, half_sel};
      LSU_LW:  load_data = rdata;
      default: load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store stage: one memory transaction or pass-through per instruction, one registered result to writeback.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ARGS_WIDTH = LSU_ARGS_WIDTH
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst_n,
  input  logic                  i_exu_valid,
  output logic                  o_lsu_ready,
  input  logic [ARGS_WIDTH-1:0] i_idu_ctr_lsu_type,
  input  logic [DATA_WIDTH-1:0] i_exu_res,
  input  logic [DATA_WIDTH-1:0] i_idu_rs2_data,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic [3:0]            o_mem_wstrb,
  input  logic                  i_mem_gnt,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_lsu_valid,
  input  logic                  i_wbu_ready,
  output logic [DATA_WIDTH-1:0] o_lsu_res,
  output logic                  o_lsu_err
);

  lsu_state_t            state, state_nxt;
  logic [ARGS_WIDTH-1:0] type_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] rs2_q;
  logic [DATA_WIDTH-1:0] res_q;
  logic                  err_q;

  logic                  in_mem;
  logic                  in_misaligned;
  logic                  fmt_we;
  logic [DATA_WIDTH-1:0] fmt_wdata;
  logic [3:0]            fmt_wstrb;
  logic [DATA_WIDTH-1:0] fmt_load;

  assign in_mem = is_load(i_idu_ctr_lsu_type) || is_store(i_idu_ctr_lsu_type);

  lsu_fmt u_fmt (
    .chk_type   (i_idu_ctr_lsu_type),
    .chk_addr   (i_exu_res[1:0]),
    .misaligned (in_misaligned),
    .lsu_type   (type_q),
    .addr_lo    (addr_q[1:0]),
    .rs2        (rs2_q),
    .rdata      (i_mem_rdata),
    .we         (fmt_we),
    .wdata      (fmt_wdata),
    .wstrb      (fmt_wstrb),
    .load_data  (fmt_load)
  );

  // State register; reset aborts any transaction straight back to IDLE.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) state <= IDLE;
    else              state <= state_nxt;
  end

  // Next state and handshake outputs; memory-side outputs are only driven while requesting.
  always_comb begin
    state_nxt   = state;
    o_lsu_ready = 1'b0;
    o_lsu_valid = 1'b0;
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_wstrb = 4'b0000;
    case (state)
      IDLE: begin
        o_lsu_ready = 1'b1;
        if (i_exu_valid)
          state_nxt = (in_mem && !in_misaligned) ? REQ : RESP;
      end
      REQ: begin
        o_mem_req   = 1'b1;
        o_mem_we    = fmt_we;
        o_mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        o_mem_wdata = fmt_wdata;
        o_mem_wstrb = fmt_wstrb;
        if (i_mem_gnt) state_nxt = WAIT;
      end
      WAIT: begin
        if (i_mem_rvalid) state_nxt = RESP;
      end
      RESP: begin
        o_lsu_valid = 1'b1;
        if (i_wbu_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the instruction on accept and register the result it will hand to writeback.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      type_q <= '0;
      addr_q <= '0;
      rs2_q  <= '0;
      res_q  <= '0;
      err_q  <= 1'b0;
    end else if (state == IDLE && i_exu_valid) begin
      type_q <= i_idu_ctr_lsu_type;
      addr_q <= i_exu_res[ADDR_WIDTH-1:0];
      rs2_q  <= i_idu_rs2_data;
      res_q  <= in_mem ? '0 : i_exu_res;
      err_q  <= in_misaligned;
    end else if (state == WAIT && i_mem_rvalid) begin
      res_q  <= fmt_load;
    end
  end

  assign o_lsu_res = res_q;
  assign o_lsu_err = err_q;

endmodule
